// File: rtl/cfg_reg_sequencer_if.sv
// Bus bundle between the camera register-load sequencer and its environment:
// the register ROM, the I2C master handshake and the top-level control/status.
// master modport: sequencer side. slave modport: environment side.
interface cfg_reg_sequencer_if #(
   parameter int unsigned ROM_AW = 8
);
   logic              i_start;
   logic [ROM_AW-1:0] o_rom_addr;
   logic [15:0]       i_rom_data;
   logic              o_wr;
   logic [6:0]        o_slave_addr;
   logic [7:0]        o_reg_addr;
   logic [7:0]        o_wdata;
   logic              i_busy;
   logic              i_nack_slave;
   logic              i_nack_addr;
   logic              i_nack_data;
   logic              o_done;
   logic              o_error;
   logic [ROM_AW-1:0] o_count;

   modport master (
      input  i_start, i_rom_data, i_busy, i_nack_slave, i_nack_addr, i_nack_data,
      output o_rom_addr, o_wr, o_slave_addr, o_reg_addr, o_wdata,
             o_done, o_error, o_count
   );

   modport slave (
      output i_start, i_rom_data, i_busy, i_nack_slave, i_nack_addr, i_nack_data,
      input  o_rom_addr, o_wr, o_slave_addr, o_reg_addr, o_wdata,
             o_done, o_error, o_count
   );
endinterface

// File: rtl/cfg_reg_sequencer.sv
// Camera register-load sequencer: walks a synchronous ROM of {reg, val}
// entries and issues one I2C write per entry through the master's wr/busy
// handshake. 16'hFFFF ends the sequence, 16'hF0nn waits nn milliseconds.
// Optional feature macro: CFG_RETRY_EN (re-issue a NACKed entry up to
// MAX_RETRY times before aborting). Default build aborts on the first NACK.
module cfg_reg_sequencer #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h21,
   parameter int unsigned ROM_AW      = 8,
   parameter int unsigned CLKS_PER_MS = 100000
`ifdef CFG_RETRY_EN
   ,
   parameter int unsigned MAX_RETRY   = 3
`endif
) (
   input  logic                i_clk,
   input  logic                i_rst,
   cfg_reg_sequencer_if.master bus
);

   localparam int unsigned DLY_W    = $clog2(255 * CLKS_PER_MS + 1);
   localparam logic [15:0] END_MARK = 16'hFFFF;
   localparam logic [7:0]  DLY_TAG  = 8'hF0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAITIDLE,
      S_ISSUE,
      S_XFER,
      S_CHECK,
      S_DELAY,
      S_ERROR,
      S_DONE
   } state_t;

   state_t            state_q,    state_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic              wr_q,       wr_d;
   logic [7:0]        reg_addr_q, reg_addr_d;
   logic [7:0]        wdata_q,    wdata_d;
   logic              done_q,     done_d;
   logic              error_q,    error_d;
   logic [ROM_AW-1:0] count_q,    count_d;
   logic              nack_acc_q, nack_acc_d;
   logic [DLY_W-1:0]  dly_q,      dly_d;

`ifdef CFG_RETRY_EN
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   logic              nack_any;
   logic              last_addr;
   state_t            adv_state;
   logic [ROM_AW-1:0] adv_addr;

   // Moving past an entry: the last ROM address finishes the sequence without wrapping.
   assign nack_any  = bus.i_nack_slave | bus.i_nack_addr | bus.i_nack_data;
   assign last_addr = (rom_addr_q == {ROM_AW{1'b1}});
   assign adv_state = last_addr ? S_DONE : S_FETCH;
   assign adv_addr  = last_addr ? rom_addr_q : rom_addr_q + ROM_AW'(1);

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         rom_addr_q <= '0;
         wr_q       <= 1'b0;
         reg_addr_q <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
         nack_acc_q <= 1'b0;
         dly_q      <= '0;
`ifdef CFG_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         wr_q       <= wr_d;
         reg_addr_q <= reg_addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         error_q    <= error_d;
         count_q    <= count_d;
         nack_acc_q <= nack_acc_d;
         dly_q      <= dly_d;
`ifdef CFG_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      wr_d       = wr_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      error_d    = error_q;
      count_d    = count_q;
      nack_acc_d = nack_acc_q;
      dly_d      = dly_q;
`ifdef CFG_RETRY_EN
      retry_d    = retry_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.i_start) begin
               count_d    = '0;
               done_d     = 1'b0;
               error_d    = 1'b0;
               rom_addr_d = '0;
`ifdef CFG_RETRY_EN
               retry_d    = '0;
`endif
               state_d    = S_FETCH;
            end
         end

         S_FETCH: state_d = S_DECODE;

         S_DECODE: begin
            if (bus.i_rom_data == END_MARK) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (bus.i_rom_data[15:8] == DLY_TAG) begin
               if (bus.i_rom_data[7:0] == 8'h00) begin
                  rom_addr_d = adv_addr;
                  done_d     = last_addr;
                  state_d    = adv_state;
               end else begin
                  dly_d   = DLY_W'(bus.i_rom_data[7:0]) * DLY_W'(CLKS_PER_MS);
                  state_d = S_DELAY;
               end
            end else begin
               reg_addr_d = bus.i_rom_data[15:8];
               wdata_d    = bus.i_rom_data[7:0];
               state_d    = S_WAITIDLE;
            end
         end

         S_WAITIDLE: begin
            if (!bus.i_busy) begin
               wr_d       = 1'b1;
               nack_acc_d = 1'b0;
               state_d    = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (bus.i_busy) begin
               wr_d       = 1'b0;
               nack_acc_d = nack_acc_q | nack_any;
               state_d    = S_XFER;
            end
         end

         // NACK flags are only trusted while the master reports busy.
         S_XFER: begin
            if (bus.i_busy) begin
               nack_acc_d = nack_acc_q | nack_any;
            end else begin
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (!nack_acc_q) begin
               count_d    = count_q + ROM_AW'(1);
               rom_addr_d = adv_addr;
               done_d     = last_addr;
               state_d    = adv_state;
`ifdef CFG_RETRY_EN
               retry_d    = '0;
`endif
            end else begin
`ifdef CFG_RETRY_EN
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_WAITIDLE;
               end else begin
                  error_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_ERROR;
               end
`else
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_ERROR;
`endif
            end
         end

         S_DELAY: begin
            if (dly_q == '0) begin
               rom_addr_d = adv_addr;
               done_d     = last_addr;
               state_d    = adv_state;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end

         S_ERROR: state_d = S_DONE;

         default: state_d = S_IDLE;
      endcase
   end

   // Every output comes straight from a register.
   assign bus.o_rom_addr   = rom_addr_q;
   assign bus.o_wr         = wr_q;
   assign bus.o_slave_addr = SLAVE_ADDR;
   assign bus.o_reg_addr   = reg_addr_q;
   assign bus.o_wdata      = wdata_q;
   assign bus.o_done       = done_q;
   assign bus.o_error      = error_q;
   assign bus.o_count      = count_q;

endmodule

// File: tb/tb_cfg_reg_sequencer.sv
// Bench for cfg_reg_sequencer: synchronous ROM model, randomised I2C master
// model with a per-issue NACK plan, and an entry-level reference model.
module tb_cfg_reg_sequencer;

   localparam int unsigned ROM_AW = 3;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned CLKS   = 10;
   localparam logic [6:0]  SA     = 7'h21;
`ifdef CFG_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
   localparam int MAXR     = 3;
`else
   localparam bit RETRY_ON = 1'b0;
   localparam int MAXR     = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic        busy_hold;
   logic        mute;
   logic        m_busy;
   logic        m_nk_slave, m_nk_addr, m_nk_data;
   logic [15:0] rom [DEPTH];
   logic [15:0] rom_q;

   bit          plan[$];
   bit          m_plan[$];
   logic [22:0] issues[$];
   logic [22:0] exp_issues[$];
   int          gaps[$];
   int          cyc = 0;
   int          last_fall = 0;
   logic        prev_busy = 1'b0;
   logic        prev_wr = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_count;
   int          exp_addr;
   bit          exp_err;

   cfg_reg_sequencer_if #(.ROM_AW(ROM_AW)) bus();

   assign bus.i_start      = start;
   assign bus.i_rom_data   = rom_q;
   assign bus.i_busy       = m_busy | busy_hold;
   assign bus.i_nack_slave = m_nk_slave;
   assign bus.i_nack_addr  = m_nk_addr;
   assign bus.i_nack_data  = m_nk_data;

   cfg_reg_sequencer #(
      .SLAVE_ADDR (SA),
      .ROM_AW     (ROM_AW),
      .CLKS_PER_MS(CLKS)
`ifdef CFG_RETRY_EN
      ,
      .MAX_RETRY  (3)
`endif
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   // Synchronous ROM: data valid one clock after the address.
   always @(posedge clk) rom_q <= rom[bus.o_rom_addr];

   // Busy-fall to wr-rise gap monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc       <= cyc + 1;
      prev_busy <= bus.i_busy;
      prev_wr   <= bus.o_wr;
      if (prev_busy && !bus.i_busy) last_fall <= cyc;
      if (!prev_wr && bus.o_wr) gaps.push_back(cyc - last_fall);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // I2C master model: random accept latency and length, NACK pulse mid-transfer
   // when planned, and a stray NACK flag right as busy falls on ACKed transfers.
   initial begin
      bit nk;
      int len;
      int which;
      m_busy = 1'b0; m_nk_slave = 1'b0; m_nk_addr = 1'b0; m_nk_data = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.o_wr === 1'b1 && !mute && !busy_hold && !rst) begin
            issues.push_back({bus.o_slave_addr, bus.o_reg_addr, bus.o_wdata});
            nk = (m_plan.size() > 0) ? m_plan.pop_front() : 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            m_busy = 1'b1;
            len    = int'($urandom_range(3, 8));
            which  = int'($urandom_range(0, 2));
            for (int i = 0; i < len; i++) begin
               @(posedge clk); #1;
               m_nk_slave = nk && (i == len / 2) && (which == 0);
               m_nk_addr  = nk && (i == len / 2) && (which == 1);
               m_nk_data  = nk && (i == len / 2) && (which == 2);
            end
            @(posedge clk); #1;
            m_busy = 1'b0; m_nk_slave = !nk; m_nk_addr = 1'b0; m_nk_data = 1'b0;
            @(posedge clk); #1;
            m_nk_slave = 1'b0;
         end
      end
   end

   // Reference: walk the ROM entry by entry, consuming one plan bit per issue.
   task automatic run_model();
      int a = 0;
      int cnt = 0;
      int pi = 0;
      int retries;
      bit nk;
      logic [15:0] e;
      exp_err = 1'b0;
      exp_issues.delete();
      while (1) begin
         e = rom[a];
         if (e == 16'hFFFF) break;
         if (e[15:8] != 8'hF0) begin
            retries = 0;
            while (1) begin
               exp_issues.push_back({SA, e});
               nk = (pi < plan.size()) ? plan[pi] : 1'b0;
               pi++;
               if (!nk) begin cnt++; break; end
               if (RETRY_ON && retries < MAXR) retries++;
               else begin exp_err = 1'b1; break; end
            end
            if (exp_err) break;
         end
         if (a == DEPTH - 1) break;
         a++;
      end
      exp_count = cnt % DEPTH;
      exp_addr  = a;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   // mode 0: plain run, 1: check start->wr latency, 2: busy held high at start
   task automatic run_seq(input string tag, input int mode);
      int t;
      bit early;
      issues.delete();
      gaps.delete();
      m_plan = plan;
      run_model();
      pulse_start();
      if (mode == 1) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         check({tag, "_lat_wr_low"}, 32'(bus.o_wr), 32'd0);
         @(posedge clk); #1;
         check({tag, "_lat_wr_high"}, 32'(bus.o_wr), 32'd1);
      end else if (mode == 2) begin
         early = 1'b0;
         repeat (50) begin
            @(posedge clk); #1;
            if (bus.o_wr) early = 1'b1;
         end
         check({tag, "_wr_while_busy"}, 32'(early), 32'd0);
         busy_hold = 1'b0;
         @(posedge clk); #1;
         check({tag, "_wr_after_idle"}, 32'(bus.o_wr), 32'd1);
      end
      t = 0;
      while (!bus.o_done && t < 4000) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_done"}, 32'(bus.o_done), 32'd1);
      repeat (4) begin @(posedge clk); #1; end
      check({tag, "_done_held"}, 32'(bus.o_done), 32'd1);
      check({tag, "_error"}, 32'(bus.o_error), 32'(exp_err));
      check({tag, "_count"}, 32'(bus.o_count), 32'(exp_count));
      check({tag, "_rom_addr"}, 32'(bus.o_rom_addr), 32'(exp_addr));
      check({tag, "_wr_idle"}, 32'(bus.o_wr), 32'd0);
      check({tag, "_n_issues"}, 32'(issues.size()), 32'(exp_issues.size()));
      for (int i = 0; i < issues.size() && i < exp_issues.size(); i++)
         check($sformatf("%s_issue%0d", tag, i), 32'(issues[i]), 32'(exp_issues[i]));
   endtask

   task automatic load_t1();
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'h1280; rom[1] = 16'hF005; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
   endtask

   initial begin
      int t;
      int r;
      logic [15:0] e;
      start = 1'b0; busy_hold = 1'b0; mute = 1'b0; rst = 1'b1;
      load_t1();

      // Reset values
      repeat (3) begin @(posedge clk); #1; end
      check("rst_rom_addr", 32'(bus.o_rom_addr), 32'd0);
      check("rst_wr", 32'(bus.o_wr), 32'd0);
      check("rst_reg_addr", 32'(bus.o_reg_addr), 32'd0);
      check("rst_wdata", 32'(bus.o_wdata), 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_error", 32'(bus.o_error), 32'd0);
      check("rst_count", 32'(bus.o_count), 32'd0);
      check("rst_slave_addr", 32'(bus.o_slave_addr), 32'(SA));
      rst = 1'b0;

      // Two writes around a 5 ms delay
      plan.delete();
      run_seq("t1", 1);
      if (gaps.size() >= 2)
         check("t1_delay_gap_in_range", 32'(gaps[1] >= 52 && gaps[1] <= 64), 32'd1);
      else
         check("t1_gap_count", 32'(gaps.size()), 32'd2);

      // Master busy after reset
      busy_hold = 1'b1;
      do_reset();
      run_seq("hold", 2);

      // NACK on entry 0, then retry plans
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'h1280; rom[1] = 16'h1101;
      plan = '{1'b1};
      run_seq("nack", 0);
      plan = '{1'b1, 1'b1, 1'b0};
      run_seq("retry_ok", 0);
      plan = '{1'b1, 1'b1, 1'b1, 1'b1};
      run_seq("retry_fail", 0);

      // Full ROM, no end marker
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0101;
      plan.delete();
      run_seq("wrap", 0);

      // Reset while a write request is pending
      load_t1();
      mute = 1'b1;
      pulse_start();
      t = 0;
      while (!bus.o_wr && t < 20) begin @(posedge clk); #1; t++; end
      check("rstw_wr_up", 32'(bus.o_wr), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstw_wr_drop", 32'(bus.o_wr), 32'd0);
      check("rstw_rom_addr", 32'(bus.o_rom_addr), 32'd0);
      busy_hold = 1'b1;
      mute = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_seq("rstw", 2);

      // Randomised ROM contents and NACK plans
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < DEPTH; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
               e = {8'hF0, 8'($urandom_range(0, 2))};
            end else if (r < 20 && i > 0) begin
               e = 16'hFFFF;
            end else begin
               e = 16'($urandom);
               if (e[15:8] == 8'hF0) e[15:8] = 8'hF1;
               if (e == 16'hFFFF) e = 16'hFFFE;
            end
            rom[i] = e;
         end
         plan.delete();
         repeat (40) plan.push_back($urandom_range(0, 3) == 0);
         run_seq($sformatf("rand%0d", n), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cfg_reg_sequencer.md
# cfg_reg_sequencer

Camera register-load sequencer, directly upstream of the I2C master in the camera configuration path. After a start pulse it walks an external synchronous ROM of {register, value} entries and issues one I2C write per entry through the master's write/busy handshake. It handles delay and end markers, and reports completion, error and the count of successful writes to the top-level control logic.

## Interface
- `SLAVE_ADDR`, 7'h21: 7-bit camera slave address driven on every write.
- `ROM_AW`, 8: ROM address width.
- `CLKS_PER_MS`, 100000: clocks per millisecond for delay entries (100 MHz).
- `MAX_RETRY`, 3: re-issues per entry after NACK; used only with `CFG_RETRY_EN`.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, synchronous active-high.
- `i_start`  in  1  start pulse; honoured only in IDLE and DONE.
- `o_rom_addr`  out  ROM_AW  ROM read address.
- `i_rom_data`  in  16  ROM entry `{reg[15:8], val[7:0]}`; valid one clock after `o_rom_addr` changes.
- `o_wr`  out  1  write request to the I2C master.
- `o_slave_addr`  out  7  always `SLAVE_ADDR`.
- `o_reg_addr`  out  8  register address of the current entry.
- `o_wdata`  out  8  write data of the current entry.
- `i_busy`  in  1  master busy.
- `i_nack_slave`, `i_nack_addr`, `i_nack_data`  in  1 each  master NACK flags.
- `o_done`  out  1  sequence finished, including on error; held until the next start.
- `o_error`  out  1  sequence aborted on NACK.
- `o_count`  out  ROM_AW  number of successful writes.

## Operation
- Reset values: `o_rom_addr`=0, `o_wr`=0, `o_reg_addr`=0, `o_wdata`=0, `o_done`=0, `o_error`=0, `o_count`=0, state IDLE.
- IDLE: on `i_start`, clear `o_count`, `o_done`, `o_error` and the retry counter, set `o_rom_addr`=0, then go to FETCH.
- FETCH, 1 cycle: the ROM registers the address. Go to DECODE.
- DECODE: sample `i_rom_data`.
  - 16'hFFFF is the end marker: go to DONE.
  - 16'hF0nn is a delay entry: load the delay counter with nn×`CLKS_PER_MS` and go to DELAY. If nn=0, advance the address and go to FETCH.
  - Any other value is a write entry: latch the register and value into `o_reg_addr`/`o_wdata`, then go to WAITIDLE.
- WAITIDLE: wait for `i_busy`=0. This covers the master's power-up busy and any transfer still running after a reset. Then go to ISSUE.
- ISSUE: assert `o_wr`=1 and clear the NACK accumulator. Hold until `i_busy`=1 is seen, then deassert `o_wr` on the next edge and go to XFER.
- XFER: every cycle with `i_busy`=1, OR `i_nack_*` into a sticky accumulator. The NACK flags are not guaranteed valid once busy falls. When `i_busy`=0, go to CHECK.
- CHECK:
  - Accumulator clear: increment `o_count`, advance `o_rom_addr`, reset the retry counter, go to FETCH.
  - Accumulator set: go to ERROR, or retry (see Configuration).
- DELAY: decrement the counter to 0, advance the address, go to FETCH.
- End of ROM: the entry at address 2^ROM_AW−1 is processed, then DONE. The address never wraps.
- DONE: `o_done`=1. `i_start` restarts from address 0.
- ERROR: `o_error`=1 and `o_done`=1 in the same cycle, then go to DONE. `o_rom_addr` stays on the failing entry.
- `i_start` in any other state is ignored.
- Reset asserted mid-sequence: all outputs take their reset values on the next edge, and `o_wr` drops immediately.

## Timing
- `o_wr` and every other output are registered.
- `o_reg_addr` and `o_wdata` are stable from ISSUE entry until the next DECODE.
- `i_start` to first `o_wr`: 4 cycles (IDLE→FETCH→DECODE→WAITIDLE→ISSUE) when `i_busy`=0.
- Between consecutive writes there are 3 cycles of sequencer overhead after busy falls (CHECK, FETCH, DECODE), plus WAITIDLE.
- A delay entry nn>0 costs nn×`CLKS_PER_MS` + 2 cycles.
- `o_count` increments in the cycle after CHECK.

## Configuration
- `CFG_RETRY_EN` defined:
  - On a NACK in CHECK with retry count < `MAX_RETRY`, increment the retry count and go back to WAITIDLE with the same entry. `o_count` is unchanged.
  - When retry count = `MAX_RETRY`, go to ERROR.
- `CFG_RETRY_EN` undefined:
  - The first NACK goes straight to ERROR.
  - `MAX_RETRY` and the retry counter are not synthesized.

## Test plan
- ROM {1280, F005, 1101, FFFF}, `CLKS_PER_MS`=10, master model ACKs all → two writes (reg 12/80, then 11/01); gap from busy-fall to second `o_wr` ≥ 52 cycles; `o_done`=1, `o_count`=2, `o_error`=0.
- `i_busy` held high 50 cycles after reset, then `i_start` → `o_wr` does not assert until the cycle after `i_busy` falls.
- Model pulses `i_nack_addr` for 1 cycle mid-transfer on entry 0, without retry → `o_error`=1, `o_done`=1, `o_count`=0, `o_rom_addr`=0.
- With `CFG_RETRY_EN`, `MAX_RETRY`=3 → NACK twice then ACK gives 3 issues of entry 0 and `o_count`=1; NACK always gives 4 issues then `o_error`=1.
- ROM filled with 16'h0101 and no end marker, `ROM_AW`=3 → exactly 8 writes, `o_count`=7'd8 wraps to 0 in 3 bits (verify `o_count`=0), `o_done`=1, `o_rom_addr`=7.
- `i_rst` asserted while `o_wr`=1 → `o_wr`=0 next edge; a new `i_start` restarts at address 0 only after `i_busy`=0.
